// File: rtl/rp8_uart_tx_if.sv
// rp8 I/O peripheral bus: the core drives strobes, address, data and mask; the responder returns read data.
interface rp8_uart_tx_if;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;

  logic          io_wen;
  logic          io_ren;
  logic [AW-1:0] io_adr;
  logic [DW-1:0] io_wdt;
  logic [DW-1:0] io_msk;
  logic [DW-1:0] io_rdt;

  modport master (output io_wen, io_ren, io_adr, io_wdt, io_msk, input io_rdt);
  modport slave  (input io_wen, io_ren, io_adr, io_wdt, io_msk, output io_rdt);
endinterface

// File: rtl/rp8_uart_tx.sv
// rp8_uart_tx: memory-mapped 8N1 UART transmitter (DATA/STAT/CTRL/BAUD at ADR+0..3) with level irq.
// Define RP8_UART_TX_FIFO_EN for a 2**FDW entry TX FIFO; otherwise a single holding register is used.
module rp8_uart_tx #(
  parameter logic [5:0]  ADR = 6'h0C,
  parameter int unsigned FDW = 2
) (
  input  logic         clk,
  input  logic         rst,
  rp8_uart_tx_if.slave bus,
  output logic         irq,
  output logic         txd
);
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 3;

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CTRL = 2'd2;
  localparam logic [1:0] OFF_BAUD = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Elaboration-time parameter sanity.
  if (ADR[1:0] != 2'b00) begin : g_adr_chk
    $error("rp8_uart_tx: ADR must be a multiple of 4");
  end
  if (FDW > 8) begin : g_fdw_chk
    $error("rp8_uart_tx: FDW out of range");
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic          wr_hit;
  logic          rd_hit;
  logic [1:0]    off;
  logic          push;
  logic          push_ok;
  logic [DW-1:0] push_data;

  assign off       = bus.io_adr[1:0];
  assign wr_hit    = bus.io_wen && (bus.io_adr[5:2] == ADR[5:2]);
  assign rd_hit    = bus.io_ren && (bus.io_adr[5:2] == ADR[5:2]);
  assign push      = wr_hit && (off == OFF_DATA);
  assign push_data = bus.io_wdt & bus.io_msk;

  // ---------------------------------------------------------------------------
  // Transmit storage
  // ---------------------------------------------------------------------------
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_empty_nx;
  logic [DW-1:0] fifo_head;
  logic          pop;

  // Full is taken from the registered state, so a push in the pop cycle of a full store is dropped.
  assign push_ok = push && !fifo_full;

`ifdef RP8_UART_TX_FIFO_EN
  if (FDW < 1) begin : g_fdw_min_chk
    $error("rp8_uart_tx: FDW must be at least 1 with the FIFO enabled");
  end

  localparam int unsigned DEPTH = 1 << FDW;
  localparam int unsigned PW    = FDW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_nx;
  logic [PW-1:0] rptr_nx;

  // Pointers carry one extra MSB to tell full from empty.
  always_comb begin
    wptr_nx = wptr_q + PW'(push_ok);
    rptr_nx = rptr_q + PW'(pop);
  end

  assign fifo_empty    = (wptr_q == rptr_q);
  assign fifo_full     = (wptr_q[FDW] != rptr_q[FDW]) &&
                         (wptr_q[FDW-1:0] == rptr_q[FDW-1:0]);
  assign fifo_empty_nx = (wptr_nx == rptr_nx);
  assign fifo_head     = mem[rptr_q[FDW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_nx;
      rptr_q <= rptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q[FDW-1:0]] <= push_data;
    end
  end
`else
  logic          hold_vld_q;
  logic          hold_vld_nx;
  logic [DW-1:0] hold_q;

  // Single holding register: occupied means full.
  always_comb begin
    hold_vld_nx = hold_vld_q;
    if (push_ok) begin
      hold_vld_nx = 1'b1;
    end else if (pop) begin
      hold_vld_nx = 1'b0;
    end
  end

  assign fifo_empty    = !hold_vld_q;
  assign fifo_full     = hold_vld_q;
  assign fifo_empty_nx = !hold_vld_nx;
  assign fifo_head     = hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_nx;
      if (push_ok) begin
        hold_q <= push_data;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  logic          ctrl_en_q,  ctrl_en_nx;
  logic          ctrl_ie_q,  ctrl_ie_nx;
  logic [CW-1:0] baud_q,     baud_nx;
  logic          ovf_q,      ovf_nx;

  always_comb begin
    ctrl_en_nx = ctrl_en_q;
    ctrl_ie_nx = ctrl_ie_q;
    baud_nx    = baud_q;
    ovf_nx     = ovf_q;
    if (wr_hit) begin
      case (off)
        OFF_DATA: begin
          if (fifo_full) begin
            ovf_nx = 1'b1;
          end
        end
        OFF_STAT: begin
          if (bus.io_wdt[3] && bus.io_msk[3]) begin
            ovf_nx = 1'b0;
          end
        end
        OFF_CTRL: begin
          {ctrl_ie_nx, ctrl_en_nx} = (bus.io_wdt[1:0] & bus.io_msk[1:0]) |
                                     ({ctrl_ie_q, ctrl_en_q} & ~bus.io_msk[1:0]);
        end
        default: begin
          baud_nx = (bus.io_wdt & bus.io_msk) | (baud_q & ~bus.io_msk);
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_nx;
  logic [CW-1:0] cnt_q,   cnt_nx;
  logic [CW-1:0] per_q,   per_nx;
  logic [IW-1:0] idx_q,   idx_nx;
  logic [DW-1:0] shr_q,   shr_nx;
  logic          txd_q,   txd_nx;
  logic          bit_end;
  logic          start_ok;
  logic          busy;

  // per_q latches BAUD at each bit boundary so mid-frame writes wait for the next bit.
  assign bit_end  = (cnt_q == per_q);
  assign start_ok = ctrl_en_q && !fifo_empty;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + CW'(1);
    per_nx   = per_q;
    idx_nx   = idx_q;
    shr_nx   = shr_q;
    txd_nx   = txd_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_nx = '0;
        txd_nx = 1'b1;
        if (start_ok) begin
          pop      = 1'b1;
          state_nx = S_START;
          txd_nx   = 1'b0;
          shr_nx   = fifo_head;
          per_nx   = baud_q;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          txd_nx   = shr_q[0];
          idx_nx   = '0;
          cnt_nx   = '0;
          per_nx   = baud_q;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nx = '0;
          per_nx = baud_q;
          if (idx_q == IW'(7)) begin
            state_nx = S_STOP;
            txd_nx   = 1'b1;
          end else begin
            idx_nx = idx_q + IW'(1);
            shr_nx = {1'b0, shr_q[DW-1:1]};
            txd_nx = shr_q[1];
          end
        end
      end
      default: begin
        if (bit_end) begin
          cnt_nx = '0;
          per_nx = baud_q;
          if (start_ok) begin
            pop      = 1'b1;
            state_nx = S_START;
            txd_nx   = 1'b0;
            shr_nx   = fifo_head;
          end else begin
            state_nx = S_IDLE;
            txd_nx   = 1'b1;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read data and interrupt
  // ---------------------------------------------------------------------------
  logic [DW-1:0] stat;
  logic [DW-1:0] rdt_q, rdt_nx;
  logic          irq_q, irq_nx;

  assign stat = {4'b0000, ovf_q, busy, fifo_full, fifo_empty};

  always_comb begin
    rdt_nx = '0;
    if (rd_hit) begin
      case (off)
        OFF_STAT: rdt_nx = stat;
        OFF_CTRL: rdt_nx = {6'b000000, ctrl_ie_q, ctrl_en_q};
        OFF_BAUD: rdt_nx = baud_q;
        default:  rdt_nx = '0;
      endcase
    end
  end

  // Built from next-state values so irq tracks the registered status without an extra cycle.
  assign irq_nx = ctrl_ie_nx && fifo_empty_nx && (state_nx == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en_q <= 1'b0;
      ctrl_ie_q <= 1'b0;
      baud_q    <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      idx_q     <= '0;
      shr_q     <= '0;
      txd_q     <= 1'b1;
      rdt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_en_q <= ctrl_en_nx;
      ctrl_ie_q <= ctrl_ie_nx;
      baud_q    <= baud_nx;
      ovf_q     <= ovf_nx;
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      per_q     <= per_nx;
      idx_q     <= idx_nx;
      shr_q     <= shr_nx;
      txd_q     <= txd_nx;
      rdt_q     <= rdt_nx;
      irq_q     <= irq_nx;
    end
  end

  assign txd        = txd_q;
  assign irq        = irq_q;
  assign bus.io_rdt = rdt_q;

endmodule

// File: tb/tb_rp8_uart_tx.sv
// Bench for rp8_uart_tx: register vector table, frame scoreboard fed by a txd decoder, timing sequences.
`timescale 1ns/1ps
module tb_rp8_uart_tx;
  localparam logic [5:0] ADR    = 6'h0C;
  localparam logic [5:0] A_DATA = 6'h0C;
  localparam logic [5:0] A_STAT = 6'h0D;
  localparam logic [5:0] A_CTRL = 6'h0E;
  localparam logic [5:0] A_BAUD = 6'h0F;
`ifdef RP8_UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic irq;
  logic txd;

  rp8_uart_tx_if bus ();

  rp8_uart_tx #(.ADR(ADR), .FDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq),
    .txd (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  int         starts[$];
  int         bit_cyc = 1;

  typedef struct {
    bit         wr;
    logic [5:0] adr;
    logic [7:0] wdt;
    logic [7:0] msk;
    logic [7:0] exp_rdt;
    logic       exp_irq;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus tasks are entered at a falling edge and return one falling edge later.
  task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
    bus.io_wen = 1'b1; bus.io_adr = a; bus.io_wdt = d; bus.io_msk = m;
    @(negedge clk);
    bus.io_wen = 1'b0; bus.io_wdt = 8'h00; bus.io_msk = 8'h00;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    bus.io_ren = 1'b1; bus.io_adr = a;
    @(negedge clk);
    bus.io_ren = 1'b0;
    d = bus.io_rdt;
  endtask

  function automatic vec_t mk(input bit w, input logic [5:0] a, input logic [7:0] d,
                              input logic [7:0] m, input logic [7:0] e, input logic ei);
    vec_t v;
    v.wr = w; v.adr = a; v.wdt = d; v.msk = m; v.exp_rdt = e; v.exp_irq = ei;
    return v;
  endfunction

  // Decodes txd frames by mid-bit sampling and checks them against the scoreboard.
  task automatic monitor();
    logic       act;
    int         pos;
    int         k;
    logic [7:0] sh;
    act = 1'b0; pos = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (txd == 1'b0) begin
          act = 1'b1; pos = 0;
          starts.push_back(cyc);
        end
      end else begin
        pos++;
      end
      if (act && rst && ((pos % bit_cyc) == (bit_cyc / 2))) begin
        k = pos / bit_cyc;
        if (k >= 1 && k <= 8) begin
          sh[k-1] = txd;
        end else if (k == 9) begin
          check("stop_bit", txd, 1);
          if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_frame: got 0x%02h, expected no frame", sh);
          end else begin
            check("frame_byte", sh, sb_q.pop_front());
          end
          act = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic       exp_txd;
    int         sz;
    int         lows;
    bit         done;

    bus.io_wen = 1'b0; bus.io_ren = 1'b0; bus.io_adr = 6'h00;
    bus.io_wdt = 8'h00; bus.io_msk = 8'h00;
    rst = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    check("rst_rdt", bus.io_rdt, 0);
    rd(A_STAT, d); check("rst_stat", d, 8'h01);

    // Register access table
    vt.push_back(mk(1, A_BAUD, 8'hFF, 8'hFF, 8'h00, 0));
    vt.push_back(mk(0, A_BAUD, 8'h00, 8'h00, 8'hFF, 0));
    vt.push_back(mk(1, A_BAUD, 8'h00, 8'h0F, 8'h00, 0));
    vt.push_back(mk(0, A_BAUD, 8'h00, 8'h00, 8'hF0, 0));
    vt.push_back(mk(1, A_BAUD, 8'h05, 8'hFF, 8'h00, 0));
    vt.push_back(mk(0, A_BAUD, 8'h00, 8'h00, 8'h05, 0));
    vt.push_back(mk(1, A_CTRL, 8'h01, 8'hFF, 8'h00, 0));
    vt.push_back(mk(1, A_CTRL, 8'hFF, 8'h02, 8'h00, 0));
    vt.push_back(mk(0, A_CTRL, 8'h00, 8'h00, 8'h03, 1));
    vt.push_back(mk(1, A_CTRL, 8'h00, 8'h01, 8'h00, 0));
    vt.push_back(mk(0, A_CTRL, 8'h00, 8'h00, 8'h02, 1));
    vt.push_back(mk(0, A_DATA, 8'h00, 8'h00, 8'h00, 1));
    vt.push_back(mk(1, 6'h10,  8'hFF, 8'hFF, 8'h00, 0));
    vt.push_back(mk(0, A_CTRL, 8'h00, 8'h00, 8'h02, 1));
    vt.push_back(mk(0, A_BAUD, 8'h00, 8'h00, 8'h05, 1));
    vt.push_back(mk(0, 6'h10,  8'h00, 8'h00, 8'h00, 1));
    vt.push_back(mk(1, 6'h0A,  8'hFF, 8'hFF, 8'h00, 0));
    vt.push_back(mk(0, A_CTRL, 8'h00, 8'h00, 8'h02, 1));
    vt.push_back(mk(1, A_CTRL, 8'h00, 8'hFF, 8'h00, 0));
    vt.push_back(mk(0, A_STAT, 8'h00, 8'h00, 8'h01, 0));
    vt.push_back(mk(1, A_STAT, 8'hFF, 8'hFF, 8'h00, 0));
    vt.push_back(mk(0, A_STAT, 8'h00, 8'h00, 8'h01, 0));
    foreach (vt[i]) begin
      if (vt[i].wr) begin
        wr(vt[i].adr, vt[i].wdt, vt[i].msk);
      end else begin
        rd(vt[i].adr, d);
        check($sformatf("vec%0d_rdt", i), d, vt[i].exp_rdt);
        check($sformatf("vec%0d_irq", i), irq, vt[i].exp_irq);
      end
    end

    // 8'hA5 at BAUD=3: exact per-cycle txd and busy window
    wr(A_BAUD, 8'h03, 8'hFF); bit_cyc = 4;
    wr(A_CTRL, 8'h01, 8'hFF);
    b = 8'hA5;
    sb_q.push_back(b);
    wr(A_DATA, b, 8'hFF);
    check("a5_txd_pre", txd, 1);
    for (int i = 0; i <= 41; i++) begin
      @(negedge clk);
      if (i < 4)       exp_txd = 1'b0;
      else if (i < 36) exp_txd = b[(i - 4) / 4];
      else             exp_txd = 1'b1;
      check($sformatf("a5_txd_c%0d", i), txd, exp_txd);
      if (i == 1 || i == 40 || i == 41)
        check($sformatf("a5_busy_c%0d", i), bus.io_rdt[2], (i != 41) ? 1 : 0);
      bus.io_ren = (i == 0 || i == 39 || i == 40);
      bus.io_adr = A_STAT;
    end

    // Interrupt behaviour around one frame
    wr(A_CTRL, 8'h03, 8'hFF);
    check("irq_idle_empty", irq, 1);
    sb_q.push_back(8'h3C);
    wr(A_DATA, 8'h3C, 8'hFF);
    check("irq_after_push", irq, 0);
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i == 20 || i == 39) check($sformatf("irq_busy_c%0d", i), irq, 0);
      if (i == 40)            check("irq_after_stop", irq, 1);
    end
    wr(A_CTRL, 8'h00, 8'h02);
    check("irq_ie_clear", irq, 0);

    // Back-to-back frames with zero gap at BAUD=1
    wr(A_BAUD, 8'h01, 8'hFF); bit_cyc = 2;
    sz = starts.size();
    sb_q.push_back(8'h11);
    wr(A_DATA, 8'h11, 8'hFF);
    @(negedge clk);
    sb_q.push_back(8'h22);
    wr(A_DATA, 8'h22, 8'hFF);
    repeat (50) @(negedge clk);
    check("b2b_frames", starts.size() - sz, 2);
    if (starts.size() >= sz + 2) check("b2b_gap", starts[sz+1] - starts[sz], 20);

    // Overflow, W1C masking, and drop of a push in the pop cycle of a full store
    wr(A_CTRL, 8'h00, 8'hFF);
    for (int k = 0; k <= DEPTH; k++) begin
      if (k < DEPTH) sb_q.push_back(8'h80 + 8'(k));
      wr(A_DATA, 8'h80 + 8'(k), 8'hFF);
    end
    rd(A_STAT, d); check("ovf_full", d, 8'h0A);
    wr(A_STAT, 8'h08, 8'hF7);
    rd(A_STAT, d); check("ovf_mask_keep", d, 8'h0A);
    wr(A_STAT, 8'h08, 8'h08);
    rd(A_STAT, d); check("ovf_clear", d, 8'h02);
    wr(A_CTRL, 8'h01, 8'hFF);
    wr(A_DATA, 8'h77, 8'hFF);
    done = 1'b0;
    for (int t = 0; t < 600 && !done; t++) begin
      rd(A_STAT, d);
      if (d[2:0] == 3'b001) done = 1'b1;
    end
    check("drain_done", done, 1);
    check("drop_on_pop", d, 8'h09);
    wr(A_STAT, 8'h08, 8'h08);

    // Reset in the middle of a data bit
    wr(A_BAUD, 8'h03, 8'hFF); bit_cyc = 4;
    wr(A_DATA, 8'h5A, 8'hFF);
    @(negedge clk);
    wr(A_DATA, 8'hC3, 8'hFF);
    repeat (12) @(negedge clk);
    check("pre_rst_txd", txd, 0);
    #2 rst = 1'b0;
    #1 check("rst_async_txd", txd, 1);
    check("rst_async_irq", irq, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1; bit_cyc = 1;
    @(negedge clk);
    rd(A_STAT, d); check("rst_stat_after", d, 8'h01);
    rd(A_CTRL, d); check("rst_ctrl_after", d, 8'h00);
    rd(A_BAUD, d); check("rst_baud_after", d, 8'h00);
    wr(A_CTRL, 8'h01, 8'hFF);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    check("no_residual_frame", lows, 0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
